// File: rtl/mont_mult_if.sv
// Operand/result bundle between the RSA exponentiation controller and mont_mult.
interface mont_mult_if #(
  parameter int WIDTH = 256
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [WIDTH-1:0] i_n;
  logic [WIDTH-1:0] o_m;
  logic             o_finished;

  modport master (
    output i_start, i_a, i_b, i_n,
    input  o_m, o_finished
  );

  modport slave (
    input  i_start, i_a, i_b, i_n,
    output o_m, o_finished
  );
endinterface

// File: rtl/mont_mult.sv
// Bit-serial radix-2 Montgomery multiplier: o_m = a*b*2^-WIDTH mod n.
// Optional MONT_UNROLL2_EN retires two multiplier bits per clock (WIDTH must be even).
module mont_mult #(
  parameter int WIDTH = 256
) (
  input logic        i_clk,
  input logic        i_rst,
  mont_mult_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SUB, S_DONE} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
`ifdef MONT_UNROLL2_EN
  localparam logic [CW-1:0] STEP = CW'(2);
`else
  localparam logic [CW-1:0] STEP = CW'(1);
`endif
  localparam logic [CW-1:0] LAST = CW'(WIDTH) - STEP;

  state_t             state;
  logic [WIDTH+1:0]   acc;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   m_q;
  logic               fin_q;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   n_q;
  logic [WIDTH+1:0]   acc_next;

  // One radix-2 step; two extra bits hold t < 2n + b without overflow.
  function automatic logic [WIDTH+1:0] mont_step(
    input logic [WIDTH+1:0] acc_in,
    input logic             a_bit,
    input logic [WIDTH-1:0] b_op,
    input logic [WIDTH-1:0] n_op
  );
    logic [WIDTH+1:0] t;
    t = acc_in + (a_bit ? {2'b00, b_op} : '0);
    if (t[0]) t = t + {2'b00, n_op};
    return t >> 1;
  endfunction

  // acc < 2n, so one conditional subtraction fully reduces it.
  function automatic logic [WIDTH-1:0] final_reduce(
    input logic [WIDTH+1:0] acc_in,
    input logic [WIDTH-1:0] n_op
  );
    logic [WIDTH+1:0] d;
    d = acc_in - {2'b00, n_op};
    return (acc_in >= {2'b00, n_op}) ? d[WIDTH-1:0] : acc_in[WIDTH-1:0];
  endfunction

  always_comb begin
    acc_next = mont_step(acc, a_sh[0], b_q, n_q);
`ifdef MONT_UNROLL2_EN
    acc_next = mont_step(acc_next, a_sh[1], b_q, n_q);
`endif
  end

  // Operand latch: multiplier shifts right so the current bit is always a_sh[0].
  always_ff @(posedge i_clk) begin
    if (state == S_IDLE && bus.i_start) begin
      a_sh <= bus.i_a;
      b_q  <= bus.i_b;
      n_q  <= bus.i_n;
    end else if (state == S_CALC) begin
      a_sh <= a_sh >> STEP;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
      acc   <= '0;
      count <= '0;
      m_q   <= '0;
      fin_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          fin_q <= 1'b0;
          if (bus.i_start) begin
            acc   <= '0;
            count <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc   <= acc_next;
          count <= count + STEP;
          if (count == LAST) state <= S_SUB;
        end
        S_SUB: begin
          m_q   <= final_reduce(acc, n_q);
          fin_q <= 1'b1;
          state <= S_DONE;
        end
        default: begin
          fin_q <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_m        = m_q;
  assign bus.o_finished = fin_q;

endmodule
